// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-over-UART host checker.
package aes_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    SEND_WAIT,
    RX_CIPHER,
    RX_PLAIN,
    FINISH
  } state_t;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] LFSR_TAPS   = 8'h1D;

  function automatic logic [7:0] lfsr_next(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/byte_lfsr8.sv
// 8-bit Galois LFSR payload source; load wins over advance.
module byte_lfsr8
  import aes_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] out_byte
);

  always_ff @(posedge clk) begin
    if (!reset_n)     out_byte <= 8'h00;
    else if (load)    out_byte <= seed;
    else if (advance) out_byte <= lfsr_next(out_byte);
  end

endmodule

// File: rtl/aes_uart_host_checker.sv
// Host end of the AES-over-UART self-test: sends an LFSR payload, checks the echo.
// Optional build macro AES_HOST_BYPASS_DETECT_EN adds the bypass_detect output.
module aes_uart_host_checker
  import aes_uart_pkg::*;
#(
  parameter int         NUM_BLOCKS     = 2,
  parameter logic [7:0] SEED           = 8'h01,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  output logic [7:0]                             tx_data,
  output logic                                   tx_start,
  input  logic                                   tx_done,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_done,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   pass,
  output logic                                   timeout,
  output logic [$clog2(NUM_BLOCKS*16+1)-1:0]     mismatch_count,
  output logic [$clog2(NUM_BLOCKS*16)-1:0]       first_err_index,
`ifdef AES_HOST_BYPASS_DETECT_EN
  output logic                                   bypass_detect,
`endif
  output state_t                                 dbg_state
);

  localparam int NBYTES = NUM_BLOCKS * BLOCK_BYTES;
  localparam int KW     = $clog2(NBYTES + 1);
  localparam int IW     = $clog2(NBYTES);
  localparam int WW     = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [WW-1:0] wd_q;
  logic [7:0]    buf_mem [NBYTES];
  logic [7:0]    lfsr_byte;
  logic [IW-1:0] idx;
  logic          k_last, wd_expired, wd_active, bypass_flag;

  assign idx        = k_q[IW-1:0];
  assign k_last     = (k_q == KW'(NBYTES - 1));
  assign wd_expired = (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign wd_active  = (state_q == SEND_WAIT) || (state_q == RX_CIPHER) || (state_q == RX_PLAIN);
  assign dbg_state  = state_q;

  byte_lfsr8 u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state_q == IDLE && start),
    .seed     (SEED),
    .advance  (state_q == SEND_WAIT && tx_done),
    .out_byte (lfsr_byte)
  );

  // Handshakes: tx_start is a one-cycle request and tx_done its one-cycle completion;
  // only one byte is ever outstanding. rx_done is an unconditional one-cycle strobe
  // qualifying rx_data; there is no backpressure on the receive side.
  always_comb begin
    state_d  = state_q;
    tx_start = (state_q == SEND);
    tx_data  = (state_q == SEND || state_q == SEND_WAIT) ? lfsr_byte : 8'h00;
    unique case (state_q)
      IDLE:      if (start) state_d = SEND;
      SEND:      state_d = SEND_WAIT;
      SEND_WAIT: if (tx_done) state_d = k_last ? RX_CIPHER : SEND;
                 else if (wd_expired) state_d = FINISH;
      RX_CIPHER: if (rx_done) begin
                   if (k_last) state_d = RX_PLAIN;
                 end else if (wd_expired) state_d = FINISH;
      RX_PLAIN:  if (rx_done) begin
                   if (k_last) state_d = FINISH;
                 end else if (wd_expired) state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == SEND) buf_mem[idx] <= lfsr_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      k_q             <= '0;
      wd_q            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      mismatch_count  <= '0;
      first_err_index <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      // A received or sent byte always beats a coincident expiry.
      if (!wd_active || state_d != state_q || tx_done || rx_done) wd_q <= '0;
      else                                                        wd_q <= wd_q + WW'(1);
      unique case (state_q)
        IDLE: if (start) begin
          busy            <= 1'b1;
          pass            <= 1'b0;
          timeout         <= 1'b0;
          mismatch_count  <= '0;
          first_err_index <= '0;
          k_q             <= '0;
        end
        SEND_WAIT, RX_CIPHER: begin
          if ((state_q == SEND_WAIT) ? tx_done : rx_done)
            k_q <= k_last ? '0 : k_q + KW'(1);
          else if (wd_expired)
            timeout <= 1'b1;
        end
        RX_PLAIN: begin
          if (rx_done) begin
            k_q <= k_last ? '0 : k_q + KW'(1);
            if (rx_data != buf_mem[idx]) begin
              mismatch_count <= mismatch_count + 1'b1;
              if (mismatch_count == '0) first_err_index <= idx;
            end
          end else if (wd_expired) begin
            timeout <= 1'b1;
          end
        end
        FINISH: begin
          pass <= (mismatch_count == '0) && !timeout && !bypass_flag;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_HOST_BYPASS_DETECT_EN
  logic blk_eq_q, byte_eq;
  assign byte_eq     = (rx_data == buf_mem[idx]);
  assign bypass_flag = bypass_detect;

  // A whole 16-byte block of ciphertext equal to its plaintext means the AES core was bypassed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk_eq_q      <= 1'b0;
      bypass_detect <= 1'b0;
    end else if (state_q == IDLE && start) begin
      blk_eq_q      <= 1'b0;
      bypass_detect <= 1'b0;
    end else if (state_q == RX_CIPHER && rx_done) begin
      blk_eq_q <= (k_q[3:0] == 4'h0) ? byte_eq : (blk_eq_q & byte_eq);
      if (k_q[3:0] == 4'hF && blk_eq_q && byte_eq) bypass_detect <= 1'b1;
    end
  end
`else
  assign bypass_flag = 1'b0;
`endif

endmodule
